pipelined_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder. It is the sequential successor to the team's combinational half adder.
- Splits a WIDTH-bit add into STAGES equal chunks. One chunk is added per pipeline stage, and each stage's carry is registered between stages.
- Sits between producer and consumer blocks using valid/ready handshakes on both sides. Accepts one operation per cycle at full throughput.

---
 rtl/pipelined_adder.sv | 145 ++++++++++++++
 tb/tb_pipelined_adder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple-carry adder split into STAGES equal chunks,
// one chunk per pipeline stage, with the inter-chunk carry registered between
// stages. Valid/ready handshakes on both sides; bubble-collapsing flow control
// lets an empty stage fill even while the output is stalled.
// Optional feature: define PIPELINED_ADDER_OVF_EN to add the registered
// two's-complement overflow output ovf, aligned with sum/cout.
// WIDTH must be a multiple of STAGES.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  // One chunk of the ripple add: returns {carry_out, chunk_sum}.
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             c);
    add_chunk = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
  endfunction

  // Per-stage word: lower chunks hold finished sum bits, upper chunks still
  // hold operand A; b_q keeps operand B for the chunks not yet added.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] rdy;

  logic [WIDTH-1:0]  src_a, src_b;
  logic              src_c, src_v;
  logic [CHUNK:0]    chunk_r;

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Stage i is ready unless it and every stage after it are full while the
  // consumer stalls; written without a bit-chain so no combinational loop
  // appears between bits of rdy.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < STAGES; i++) begin
      rdy[i] = out_ready || !(&(v_q | ~({STAGES{1'b1}} << i)));
    end
  end

  // Next-state for every stage: load from upstream when ready, add this
  // stage's chunk; data only moves with a valid operation so the output
  // registers stay at their reset value until the first real result.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    v_d     = v_q;
    src_a   = '0;
    src_b   = '0;
    src_c   = 1'b0;
    src_v   = 1'b0;
    chunk_r = '0;
`ifdef PIPELINED_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    for (int i = 0; i < STAGES; i++) begin
      if (i == 0) begin
        src_a = A;
        src_b = B;
        src_c = cin;
        src_v = in_valid;
      end else begin
        src_a = a_q[(i == 0) ? 0 : i - 1];
        src_b = b_q[(i == 0) ? 0 : i - 1];
        src_c = c_q[(i == 0) ? 0 : i - 1];
        src_v = v_q[(i == 0) ? 0 : i - 1];
      end
      if (rdy[i]) begin
        v_d[i] = src_v;
      end
      if (rdy[i] && src_v) begin
        chunk_r                  = add_chunk(src_a[i*CHUNK +: CHUNK],
                                             src_b[i*CHUNK +: CHUNK], src_c);
        a_d[i]                   = src_a;
        a_d[i][i*CHUNK +: CHUNK] = chunk_r[CHUNK-1:0];
        b_d[i]                   = src_b;
        c_d[i]                   = chunk_r[CHUNK];
`ifdef PIPELINED_ADDER_OVF_EN
        // Carry into the MSB is a^b^s at that bit; overflow is it XOR cout.
        if (i == STAGES - 1) begin
          ovf_d = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ chunk_r[CHUNK-1] ^ chunk_r[CHUNK];
        end
`endif
      end
    end
  end

  // Pipeline registers; reset clears valid bits and all data immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      v_q <= v_d;
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = a_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4) with hand-computed
// expected sums. Define PIPELINED_ADDER_OVF_EN to also exercise ovf.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] A, B;
  logic             cin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic v);
    A        = a;
    B        = b;
    cin      = c;
    in_valid = v;
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] s, input logic co);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_sum"},   {16'd0, sum},       {16'd0, s});
    check({tag, "_cout"},  {31'd0, cout},      {31'd0, co});
  endtask

  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset asserted mid-cycle, before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_sum",       {16'd0, sum},       32'h0);
    check("rst_cout",      {31'd0, cout},      32'h0);
    check("rst_out_valid", {31'd0, out_valid}, 32'h0);
    check("rst_in_ready",  {31'd0, in_ready},  32'h1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    // Idle with junk on the operand lines: outputs must stay cleared.
    drive(16'h5A5A, 16'hA5A5, 1'b1, 1'b0);
    step();
    step();
    check("idle_out_valid", {31'd0, out_valid}, 32'h0);
    check("idle_sum",       {16'd0, sum},       32'h0);
    check("idle_in_ready",  {31'd0, in_ready},  32'h1);

    // Carry ripple through all four chunks, latency exactly 4 edges.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    step();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    check("lat_e1", {31'd0, out_valid}, 32'h0);
    step();
    check("lat_e2", {31'd0, out_valid}, 32'h0);
    step();
    check("lat_e3", {31'd0, out_valid}, 32'h0);
    step();
    check_out("ripple", 16'h0000, 1'b1);
    step();
    check("ripple_gone", {31'd0, out_valid}, 32'h0);

    // Back-to-back at full throughput.
    drive(16'h1234, 16'h1111, 1'b0, 1'b1); step();
    drive(16'h00FF, 16'h0001, 1'b1, 1'b1); step();
    drive(16'h8000, 16'h8000, 1'b0, 1'b1); step();
    drive(16'hAAAA, 16'h5555, 1'b0, 1'b1); step();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    check_out("b2b_0", 16'h2345, 1'b0);
    step();
    check_out("b2b_1", 16'h0101, 1'b0);
    step();
    check_out("b2b_2", 16'h0000, 1'b1);
    step();
    check_out("b2b_3", 16'hFFFF, 1'b0);
    step();
    check("b2b_empty", {31'd0, out_valid}, 32'h0);

    // Backpressure: four ops fill the pipe, the fifth is refused.
    out_ready = 1'b0;
    drive(16'h0001, 16'h0002, 1'b0, 1'b1);
    #1 check("bp_rdy0", {31'd0, in_ready}, 32'h1);
    step();
    drive(16'h1000, 16'h2000, 1'b0, 1'b1);
    check("bp_rdy1", {31'd0, in_ready}, 32'h1);
    step();
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    check("bp_rdy2", {31'd0, in_ready}, 32'h1);
    step();
    drive(16'h0F0F, 16'hF0F0, 1'b0, 1'b1);
    check("bp_rdy3", {31'd0, in_ready}, 32'h1);
    step();
    drive(16'h4321, 16'h1234, 1'b0, 1'b1);
    check("bp_full", {31'd0, in_ready}, 32'h0);
    check_out("bp_hold0", 16'h0003, 1'b0);
    step();
    step();
    check("bp_full2", {31'd0, in_ready}, 32'h0);
    check_out("bp_hold1", 16'h0003, 1'b0);
    out_ready = 1'b1;
    #1 check("bp_release_rdy", {31'd0, in_ready}, 32'h1);
    step();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    check_out("bp_d1", 16'h3000, 1'b0);
    step();
    check_out("bp_d2", 16'hFFFF, 1'b1);
    step();
    check_out("bp_d3", 16'hFFFF, 1'b0);
    step();
    check_out("bp_d4", 16'h5555, 1'b0);
    step();
    check("bp_empty", {31'd0, out_valid}, 32'h0);

    // Bubble collapse: one op, two idle cycles, then stall the output.
    drive(16'h0100, 16'h0200, 1'b0, 1'b1);
    step();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    out_ready = 1'b0;
    step();
    step();
    drive(16'h1111, 16'h1111, 1'b0, 1'b1);
    check("bub_rdy1", {31'd0, in_ready}, 32'h1);
    step();
    drive(16'h7000, 16'h7000, 1'b0, 1'b1);
    check("bub_rdy2", {31'd0, in_ready}, 32'h1);
    step();
    drive(16'hFFFE, 16'h0001, 1'b1, 1'b1);
    check("bub_rdy3", {31'd0, in_ready}, 32'h1);
    step();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    check("bub_full", {31'd0, in_ready}, 32'h0);
    check_out("bub_hold", 16'h0300, 1'b0);
    out_ready = 1'b1;
    step();
    check_out("bub_d1", 16'h2222, 1'b0);
    step();
    check_out("bub_d2", 16'hE000, 1'b0);
    step();
    check_out("bub_d3", 16'h0000, 1'b1);
    step();
    check("bub_empty", {31'd0, out_valid}, 32'h0);

    // Reset with three ops in flight: none may ever emerge.
    drive(16'h0010, 16'h0001, 1'b0, 1'b1); step();
    drive(16'h0020, 16'h0002, 1'b0, 1'b1); step();
    drive(16'h0030, 16'h0003, 1'b0, 1'b1); step();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mrst_out_valid", {31'd0, out_valid}, 32'h0);
    check("mrst_in_ready",  {31'd0, in_ready},  32'h1);
    check("mrst_sum",       {16'd0, sum},       32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("mrst_flushed", {31'd0, out_valid}, 32'h0);
    end

    // Pipeline works normally after the reset.
    drive(16'h1234, 16'h4321, 1'b0, 1'b1);
    step();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    step();
    step();
    step();
    check_out("post_rst", 16'h5555, 1'b0);
    step();

`ifdef PIPELINED_ADDER_OVF_EN
    // Signed overflow flag.
    drive(16'h7FFF, 16'h0000, 1'b1, 1'b1); step();
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1); step();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    step();
    step();
    check_out("ovf_a", 16'h8000, 1'b0);
    check("ovf_a_flag", {31'd0, ovf}, 32'h1);
    step();
    check_out("ovf_b", 16'h0000, 1'b1);
    check("ovf_b_flag", {31'd0, ovf}, 32'h0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
